// File: rtl/sar_pkg.sv
`timescale 1ns/1ps
// Shared types for the successive-approximation search controller:
// FSM states and the comparator response decode.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSP_LT  = 2'd0,
    RSP_EQ  = 2'd1,
    RSP_GT  = 2'd2,
    RSP_BAD = 2'd3
  } rsp_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_rsp_t;

  // Anything other than exactly one flag set is an illegal response.
  function automatic rsp_e rsp_decode(cmp_rsp_t rsp);
    rsp_e kind;
    kind = RSP_BAD;
    case ({rsp.lt, rsp.eq, rsp.gt})
      3'b100:  kind = RSP_LT;
      3'b010:  kind = RSP_EQ;
      3'b001:  kind = RSP_GT;
      default: kind = RSP_BAD;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
`timescale 1ns/1ps
// Guess/response bus between the search controller (master) and a
// magnitude-comparator responder (slave).
interface sar_search_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             cmp_valid;
  logic             A_less_B;
  logic             A_equal_B;
  logic             A_greater_B;

  modport master (
    output guess, guess_valid,
    input  cmp_valid, A_less_B, A_equal_B, A_greater_B
  );

  modport slave (
    input  guess, guess_valid,
    output cmp_valid, A_less_B, A_equal_B, A_greater_B
  );

endinterface

// File: rtl/sar_search_ctrl.sv
`timescale 1ns/1ps
// Binary-search controller: drives guesses into a magnitude comparator and
// narrows [lo, hi] until the hidden target is hit or the range empties.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  localparam int unsigned STEP_W = $clog2(WIDTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  sar_search_ctrl_if.master     cmp,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  err,
  output logic [WIDTH-1:0]      result,
  output logic [STEP_W-1:0]     steps
);

  // Two spare bits so lo can reach 2**WIDTH and hi can reach -1 without wrapping.
  localparam int unsigned BW = WIDTH + 2;
  localparam logic signed [BW-1:0] LO_INIT = '0;
  localparam logic signed [BW-1:0] HI_INIT = $signed({2'b00, {WIDTH{1'b1}}});

  state_e                state_q, state_nxt;
  logic signed [BW-1:0]  lo_q, hi_q;
  logic signed [BW-1:0]  guess_x, lo_lt, hi_gt;
  logic [WIDTH-1:0]      guess_q, mid;
  logic [WIDTH:0]        sum;
  logic                  guess_valid_q;
  logic                  busy_nxt, done_nxt, gv_nxt;
  cmp_rsp_t              rsp_raw;
  rsp_e                  rsp_kind;
  logic                  accept, exhausted;

  assign cmp.guess       = guess_q;
  assign cmp.guess_valid = guess_valid_q;

  assign rsp_raw  = '{lt: cmp.A_less_B, eq: cmp.A_equal_B, gt: cmp.A_greater_B};
  assign rsp_kind = rsp_decode(rsp_raw);
  assign accept   = (state_q == WAIT) && cmp.cmp_valid;

  // Midpoint of a non-empty range; both bounds are in 0..2**WIDTH-1 here.
  assign sum = {1'b0, lo_q[WIDTH-1:0]} + {1'b0, hi_q[WIDTH-1:0]};
  assign mid = WIDTH'(sum >> 1);

  assign guess_x   = $signed({2'b00, guess_q});
  assign lo_lt     = guess_x + BW'(1);
  assign hi_gt     = guess_x - BW'(1);
  assign exhausted = (rsp_kind == RSP_LT) ? (lo_lt > hi_q) : (hi_gt < lo_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:   if (start) state_nxt = SEARCH;
      SEARCH: state_nxt = WAIT;
      WAIT: begin
        if (accept) begin
          case (rsp_kind)
            RSP_LT, RSP_GT: state_nxt = exhausted ? FINISH : SEARCH;
            default:        state_nxt = FINISH;
          endcase
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    busy_nxt = 1'b0;
    gv_nxt   = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      SEARCH:  busy_nxt = 1'b1;
      WAIT: begin
        busy_nxt = 1'b1;
        gv_nxt   = 1'b1;
      end
      FINISH:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      guess_valid_q <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy          <= busy_nxt;
      guess_valid_q <= gv_nxt;
      done          <= done_nxt;
    end
  end

  // Search bounds, guess and the held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= LO_INIT;
      hi_q    <= HI_INIT;
      guess_q <= '0;
      found   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      steps   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            lo_q   <= LO_INIT;
            hi_q   <= HI_INIT;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            steps  <= '0;
          end
        end
        SEARCH: guess_q <= mid;
        WAIT: begin
          if (cmp.cmp_valid) begin
            steps <= steps + STEP_W'(1);
            case (rsp_kind)
              RSP_EQ: begin
                result <= guess_q;
                found  <= 1'b1;
              end
              RSP_LT: lo_q <= lo_lt;
              RSP_GT: hi_q <= hi_gt;
              default: begin
                err   <= 1'b1;
                found <= 1'b0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
`timescale 1ns/1ps
// Bench for sar_search_ctrl: WIDTH=8 and WIDTH=2 instances, each answered by a
// comparator-style responder, checked against a plain-integer search model.
module tb_sar_search_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, start2 = 1'b0;
  logic       busy8, done8, found8, err8;
  logic [7:0] result8;
  logic [3:0] steps8;
  logic       busy2, done2, found2, err2;
  logic [1:0] result2;
  logic [1:0] steps2;

  sar_search_ctrl_if #(.WIDTH(8)) bus8 ();
  sar_search_ctrl_if #(.WIDTH(2)) bus2 ();

  sar_search_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .cmp(bus8.master),
    .busy(busy8), .done(done8), .found(found8), .err(err8),
    .result(result8), .steps(steps8)
  );

  sar_search_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmp(bus2.master),
    .busy(busy2), .done(done2), .found(found2), .err(err2),
    .result(result2), .steps(steps2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: textbook binary search over integers.
  int exp_q[$];
  int e_found, e_err, e_res, e_steps;

  task automatic model(input int w, input int tgt, input int mode, input int badr);
    int lo, hi, g, r;
    lo = 0; hi = (1 << w) - 1; r = 0;
    exp_q.delete();
    e_found = 0; e_err = 0; e_res = 0; e_steps = 0;
    while (1) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      r++;
      e_steps = r;
      if (mode == 2 && r == badr) begin e_err = 1; break; end
      if (mode == 1 || g > tgt) hi = g - 1;
      else if (g < tgt)         lo = g + 1;
      else begin e_found = 1; e_res = g; break; end
      if (lo > hi) break;
    end
  endtask

  // Responders: mode 0 honest, 1 always gt, 2 lt+gt on round badr, 3 never answer.
  int tgt8 = 0, mode8 = 0, badr8 = 0, rnd8 = 0, cnt8 = 0, dcnt8 = 0;
  int tgt2 = 0, cnt2 = 0, dcnt2 = 0;
  int gq8[$];
  int gq2[$];

  always @(negedge clk) begin
    bus8.cmp_valid = 1'b0; bus8.A_less_B = 1'b0; bus8.A_equal_B = 1'b0; bus8.A_greater_B = 1'b0;
    if (!rst_n || bus8.guess_valid !== 1'b1) cnt8 = 0; else cnt8++;
    if (cnt8 == 2 && mode8 != 3) begin
      rnd8++;
      gq8.push_back(int'(bus8.guess));
      bus8.cmp_valid = 1'b1;
      if (mode8 == 1) bus8.A_greater_B = 1'b1;
      else if (mode8 == 2 && rnd8 == badr8) begin
        bus8.A_less_B = 1'b1; bus8.A_greater_B = 1'b1;
      end else begin
        bus8.A_less_B    = int'(bus8.guess) <  tgt8;
        bus8.A_equal_B   = int'(bus8.guess) == tgt8;
        bus8.A_greater_B = int'(bus8.guess) >  tgt8;
      end
    end
    if (done8 === 1'b1) dcnt8++;
  end

  always @(negedge clk) begin
    bus2.cmp_valid = 1'b0; bus2.A_less_B = 1'b0; bus2.A_equal_B = 1'b0; bus2.A_greater_B = 1'b0;
    if (!rst_n || bus2.guess_valid !== 1'b1) cnt2 = 0; else cnt2++;
    if (cnt2 == 2) begin
      gq2.push_back(int'(bus2.guess));
      bus2.cmp_valid   = 1'b1;
      bus2.A_less_B    = int'(bus2.guess) <  tgt2;
      bus2.A_equal_B   = int'(bus2.guess) == tgt2;
      bus2.A_greater_B = int'(bus2.guess) >  tgt2;
    end
    if (done2 === 1'b1) dcnt2++;
  end

  task automatic cmp_guesses(input string tag, input int got[$]);
    chk({tag, "_nguess"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_guess%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic run8(input int tgt, input int mode, input int badr, input bit poke);
    int cyc;
    string tag;
    tag = $sformatf("w8_t%0d_m%0d", tgt, mode);
    tgt8 = tgt; mode8 = mode; badr8 = badr; rnd8 = 0; gq8.delete(); dcnt8 = 0;
    model(8, tgt, mode, badr);
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start8 = (poke && cyc == 5);
    end
    start8 = 1'b0;
    chk({tag, "_timeout"}, cyc < 400, 1);
    chk({tag, "_found"}, found8, e_found);
    chk({tag, "_err"}, err8, e_err);
    chk({tag, "_result"}, result8, e_res);
    chk({tag, "_steps"}, steps8, e_steps);
    chk({tag, "_busy_fin"}, busy8, 0);
    chk({tag, "_gv_fin"}, bus8.guess_valid, 0);
    if (e_found == 1) chk({tag, "_step_bound"}, steps8 <= 9, 1);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_pulses"}, dcnt8, 1);
    chk({tag, "_done_low"}, done8, 0);
    chk({tag, "_found_hold"}, found8, e_found);
    chk({tag, "_steps_hold"}, steps8, e_steps);
    cmp_guesses(tag, gq8);
  endtask

  task automatic run2(input int tgt);
    int cyc;
    string tag;
    tag = $sformatf("w2_t%0d", tgt);
    tgt2 = tgt; gq2.delete(); dcnt2 = 0;
    model(2, tgt, 0, 0);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, "_timeout"}, cyc < 100, 1);
    chk({tag, "_found"}, found2, e_found);
    chk({tag, "_result"}, result2, e_res);
    chk({tag, "_steps"}, steps2, e_steps);
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_done_pulses"}, dcnt2, 1);
    cmp_guesses(tag, gq2);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_guess"}, bus8.guess, 0);
    chk({tag, "_gv"}, bus8.guess_valid, 0);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_done"}, done8, 0);
    chk({tag, "_found"}, found8, 0);
    chk({tag, "_err"}, err8, 0);
    chk({tag, "_result"}, result8, 0);
    chk({tag, "_steps"}, steps8, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    repeat (3) @(negedge clk);
    chk_zero8("rst");
    chk("rst_w2_busy", busy2, 0);
    chk("rst_w2_steps", steps2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Boundary targets, exhaustion without wrap, and an illegal response.
    run8(0, 0, 0, 1'b0);
    run8(255, 0, 0, 1'b0);
    run8(77, 1, 0, 1'b0);
    run8(200, 2, 2, 1'b0);

    for (int i = 0; i < 12; i++)
      run8(int'($urandom_range(0, 255)), 0, 0, i[0]);
    for (int i = 0; i < 4; i++)
      run8(int'($urandom_range(0, 255)), 2, int'($urandom_range(1, 8)), 1'b1);

    // Asynchronous reset while parked in WAIT.
    tgt8 = 50; mode8 = 3; rnd8 = 0; gq8.delete(); dcnt8 = 0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    cyc = 0;
    while (bus8.guess_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("midrst_reach_wait", cyc < 20, 1);
    repeat (2) @(negedge clk);
    chk("midrst_busy_before", busy8, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero8("midrst");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", dcnt8, 0);
    run8(int'($urandom_range(0, 255)), 0, 0, 1'b0);

    for (int t = 0; t < 4; t++) run2(t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
